// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared constants and helpers for the PWM output peripheral.
//   - NUM_PINS           : number of driven output pins
//   - CLK_DIV_DEFAULT    : default clocks per PWM count step
//   - PWM_BITS_DEFAULT   : default period counter / duty width
//   - DUTY_OFF/ALWAYS_ON : duty codes for the 8-bit register interface
//   - pin_mode_t         : per-pin drive selection
//   - pin_mode()/pin_drive() : decode enables into a mode and a pin level
package pwm_pkg;

  localparam int NUM_PINS         = 16;
  localparam int CLK_DIV_DEFAULT  = 13;
  localparam int PWM_BITS_DEFAULT = 8;

  localparam logic [7:0] DUTY_OFF       = 8'h00;
  localparam logic [7:0] DUTY_ALWAYS_ON = 8'hFF;

  typedef enum logic [1:0] {
    PIN_OFF  = 2'd0,
    PIN_HIGH = 2'd1,
    PIN_PWM  = 2'd2
  } pin_mode_t;

  // The output enable dominates: a PWM select on a disabled pin is still off.
  function automatic pin_mode_t pin_mode(input logic en_out, input logic en_pwm);
    pin_mode_t mode;
    if (!en_out) begin
      mode = PIN_OFF;
    end else if (en_pwm) begin
      mode = PIN_PWM;
    end else begin
      mode = PIN_HIGH;
    end
    return mode;
  endfunction

  function automatic logic pin_drive(input pin_mode_t mode, input logic pwm_sig);
    logic level;
    case (mode)
      PIN_HIGH: level = 1'b1;
      PIN_PWM:  level = pwm_sig;
      default:  level = 1'b0;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase
//   Prescaler plus free-running period counter for the PWM peripheral.
//   Ports:
//     clk          : system clock
//     rst          : asynchronous active-high reset
//     pwm_cnt      : current position within the PWM period
//     wrap         : combinational, high in the last clock of a period
//     period_start : registered one-clock pulse in the first clock of a period
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEFAULT,
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                wrap,
  output logic                period_start
);

  // A divide-by-1 prescaler still needs a one-bit register; it simply
  // never leaves zero, so tick is asserted every clock.
  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] prescaler;
  logic             tick;

  assign tick = (prescaler == PRE_LAST);
  assign wrap = tick && (pwm_cnt == {PWM_BITS{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // The counter relies on natural binary overflow for the 255 -> 0 wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral
//   Drives 16 pins from the SPI configuration registers. Each pin is off,
//   static high, or follows one PWM waveform shared by all PWM pins.
//   Ports:
//     clk             : system clock
//     rst             : asynchronous active-high reset
//     en_reg_out_7_0  : output enables, pins 7..0
//     en_reg_out_15_8 : output enables, pins 15..8
//     en_reg_pwm_7_0  : PWM select, pins 7..0
//     en_reg_pwm_15_8 : PWM select, pins 15..8
//     pwm_duty_cycle  : requested duty, 0x00 = always low, 0xFF = always high
//     out             : registered pin drive, bit i = pin i
//     period_start    : one-clock pulse at each PWM period boundary
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV  = CLK_DIV_DEFAULT,
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          en_reg_out_7_0,
  input  logic [7:0]          en_reg_out_15_8,
  input  logic [7:0]          en_reg_pwm_7_0,
  input  logic [7:0]          en_reg_pwm_15_8,
  input  logic [PWM_BITS-1:0] pwm_duty_cycle,
  output logic [NUM_PINS-1:0] out,
  output logic                period_start
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                wrap;
  logic [PWM_BITS-1:0] duty_shadow;
  logic                pwm_sig;
  logic [NUM_PINS-1:0] en_out;
  logic [NUM_PINS-1:0] en_pwm;
  logic [NUM_PINS-1:0] next_out;

  pwm_timebase #(
    .CLK_DIV  (CLK_DIV),
    .PWM_BITS (PWM_BITS)
  ) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .pwm_cnt      (pwm_cnt),
    .wrap         (wrap),
    .period_start (period_start)
  );

  // Duty is only taken on the last clock of a period so the waveform never
  // changes shape mid-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_shadow <= PWM_BITS'(DUTY_OFF);
    end else if (wrap) begin
      duty_shadow <= pwm_duty_cycle;
    end
  end

  // Full-scale duty is forced high so there is no single low step at the
  // top of the count.
  assign pwm_sig = (duty_shadow == PWM_BITS'(DUTY_ALWAYS_ON)) ? 1'b1
                 : (pwm_cnt < duty_shadow);

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    next_out = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      next_out[i] = pin_drive(pin_mode(en_out[i], en_pwm[i]), pwm_sig);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= next_out;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral
//   Directed bench for pwm_peripheral. dut_a runs with CLK_DIV = 2
//   (512-cycle period), dut_b with CLK_DIV = 1 (256-cycle period); both
//   share the register inputs.
module tb_pwm_peripheral;
  import pwm_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic        ps_a;
  logic        ps_b;

  int n_compared;
  int n_mismatch;
  int cyc;

  pwm_peripheral #(.CLK_DIV(2), .PWM_BITS(8)) dut_a (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out_a),
    .period_start    (ps_a)
  );

  pwm_peripheral #(.CLK_DIV(1), .PWM_BITS(8)) dut_b (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out_b),
    .period_start    (ps_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clocks elapsed since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the selected DUT pulses period_start (or limit expires,
  // leaving spacing = 0). Counts out[0] high samples; contig stays set
  // only if every high sample precedes every low sample. Optionally
  // rewrites duty right after sample change_at.
  task automatic measure(input bit use_b, input int limit, input int change_at,
                         input logic [7:0] new_duty,
                         output int highs, output int spacing, output bit contig);
    logic o;
    logic p;
    highs   = 0;
    spacing = 0;
    contig  = 1'b1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (i == change_at) duty = new_duty;
      o = use_b ? out_b[0] : out_a[0];
      p = use_b ? ps_b : ps_a;
      if (o) begin
        highs++;
        if (highs != i) contig = 1'b0;
      end
      if (p) begin
        spacing = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    repeat (3) step();
    n_compared++;
    if (out_a !== 16'h0000) begin
      n_mismatch++; $display("[TB] FAIL reset_out_a: got %h expected 0000", out_a);
    end
    n_compared++;
    if (ps_a !== 1'b0) begin
      n_mismatch++; $display("[TB] FAIL reset_period_start: got %b expected 0", ps_a);
    end
    n_compared++;
    if (out_b !== 16'h0000) begin
      n_mismatch++; $display("[TB] FAIL reset_out_b: got %h expected 0000", out_b);
    end
    #2 rst = 1'b0;
    step();
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    step();
    n_compared++;
    if (out_a !== 16'hFFFF) begin
      n_mismatch++; $display("[TB] FAIL static_all_high: got %h expected ffff", out_a);
    end
    // Mid-cycle reset must clear the pins without waiting for an edge.
    #2 rst = 1'b1;
    #1;
    n_compared++;
    if (out_a !== 16'h0000) begin
      n_mismatch++; $display("[TB] FAIL async_reset_out_a: got %h expected 0000", out_a);
    end
    n_compared++;
    if (out_b !== 16'h0000) begin
      n_mismatch++; $display("[TB] FAIL async_reset_out_b: got %h expected 0000", out_b);
    end
    step();
    #2 rst = 1'b0;
    step();
    n_compared++;
    if (out_a !== 16'hFFFF) begin
      n_mismatch++; $display("[TB] FAIL post_release_out: got %h expected ffff", out_a);
    end
    en_out = 16'h00FF;
    #1;
    n_compared++;
    if (out_a !== 16'hFFFF) begin
      n_mismatch++; $display("[TB] FAIL enable_latency_hold: got %h expected ffff", out_a);
    end
    step();
    n_compared++;
    if (out_a !== 16'h00FF) begin
      n_mismatch++; $display("[TB] FAIL static_00ff: got %h expected 00ff", out_a);
    end
  endtask

  task automatic test_duty_50();
    int highs, spacing;
    bit contig;
    $display("[TB] test_duty_50");
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h80;
    measure(1'b0, 1100, 0, 8'h00, highs, spacing, contig);
    n_compared++;
    if (cyc !== 512) begin
      n_mismatch++; $display("[TB] FAIL first_period_start_cycle: got %0d expected 512", cyc);
    end
    n_compared++;
    if (highs !== 0) begin
      n_mismatch++; $display("[TB] FAIL first_period_low: got %0d high expected 0", highs);
    end
    for (int k = 0; k < 2; k++) begin
      measure(1'b0, 600, 0, 8'h00, highs, spacing, contig);
      n_compared++;
      if (highs !== 256 || contig !== 1'b1) begin
        n_mismatch++;
        $display("[TB] FAIL duty50_high: got %0d contig %b expected 256 contig 1", highs, contig);
      end
      n_compared++;
      if (spacing !== 512) begin
        n_mismatch++; $display("[TB] FAIL duty50_spacing: got %0d expected 512", spacing);
      end
    end
  endtask

  task automatic test_extremes();
    int highs, spacing;
    bit contig;
    $display("[TB] test_extremes");
    duty = DUTY_OFF;
    measure(1'b0, 600, 0, 8'h00, highs, spacing, contig);
    for (int k = 0; k < 3; k++) begin
      measure(1'b0, 600, 0, 8'h00, highs, spacing, contig);
      n_compared++;
      if (highs !== 0 || spacing !== 512) begin
        n_mismatch++;
        $display("[TB] FAIL duty00: got %0d high spacing %0d expected 0 high spacing 512", highs, spacing);
      end
    end
    duty = DUTY_ALWAYS_ON;
    measure(1'b0, 600, 0, 8'h00, highs, spacing, contig);
    for (int k = 0; k < 3; k++) begin
      measure(1'b0, 600, 0, 8'h00, highs, spacing, contig);
      n_compared++;
      if (highs !== 512 || spacing !== 512) begin
        n_mismatch++;
        $display("[TB] FAIL dutyff: got %0d high spacing %0d expected 512 high spacing 512", highs, spacing);
      end
    end
  endtask

  task automatic test_double_buffer();
    int highs, spacing;
    bit contig;
    $display("[TB] test_double_buffer");
    duty = 8'h40;
    measure(1'b0, 600, 0, 8'h00, highs, spacing, contig);
    // Cycle 20 of the period is where pwm_cnt reaches 10 at CLK_DIV = 2.
    measure(1'b0, 600, 20, 8'hC0, highs, spacing, contig);
    n_compared++;
    if (highs !== 128 || contig !== 1'b1) begin
      n_mismatch++; $display("[TB] FAIL midperiod_change_ignored: got %0d high expected 128", highs);
    end
    // Cycle 511 is the wrap cycle itself; the new value must be captured.
    measure(1'b0, 600, 511, 8'h20, highs, spacing, contig);
    n_compared++;
    if (highs !== 384 || contig !== 1'b1) begin
      n_mismatch++; $display("[TB] FAIL next_period_applied: got %0d high expected 384", highs);
    end
    measure(1'b0, 600, 0, 8'h00, highs, spacing, contig);
    n_compared++;
    if (highs !== 64 || contig !== 1'b1) begin
      n_mismatch++; $display("[TB] FAIL wrap_cycle_capture: got %0d high expected 64", highs);
    end
  endtask

  task automatic test_mixed_modes();
    $display("[TB] test_mixed_modes");
    // Entered right after a period_start sample with duty 0x20 loaded.
    en_out = 16'hFFFF;
    en_pwm = 16'hF0F0;
    step();
    n_compared++;
    if (out_a !== 16'hFFFF) begin
      n_mismatch++; $display("[TB] FAIL mixed_high_phase: got %h expected ffff", out_a);
    end
    repeat (9) step();
    en_out = 16'h7FFF;
    step();
    n_compared++;
    if (out_a !== 16'h7FFF) begin
      n_mismatch++; $display("[TB] FAIL clear_pin15: got %h expected 7fff", out_a);
    end
    repeat (53) step();
    n_compared++;
    if (out_a !== 16'h7FFF) begin
      n_mismatch++; $display("[TB] FAIL mixed_last_high: got %h expected 7fff", out_a);
    end
    step();
    n_compared++;
    if (out_a !== 16'h0F0F) begin
      n_mismatch++; $display("[TB] FAIL mixed_first_low: got %h expected 0f0f", out_a);
    end
    repeat (35) step();
    n_compared++;
    if (out_a !== 16'h0F0F) begin
      n_mismatch++; $display("[TB] FAIL mixed_low_phase: got %h expected 0f0f", out_a);
    end
  endtask

  task automatic test_timebase_div1();
    int highs, spacing;
    bit contig;
    $display("[TB] test_timebase_div1");
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h01;
    measure(1'b1, 300, 0, 8'h00, highs, spacing, contig);
    for (int k = 0; k < 2; k++) begin
      measure(1'b1, 300, 0, 8'h00, highs, spacing, contig);
      n_compared++;
      if (highs !== 1 || contig !== 1'b1) begin
        n_mismatch++; $display("[TB] FAIL div1_high: got %0d contig %b expected 1 contig 1", highs, contig);
      end
      n_compared++;
      if (spacing !== 256) begin
        n_mismatch++; $display("[TB] FAIL div1_spacing: got %0d expected 256", spacing);
      end
    end
  endtask

  initial begin
    n_compared = 0;
    n_mismatch = 0;
    rst    = 1'b1;
    en_out = 16'h0000;
    en_pwm = 16'h0000;
    duty   = 8'h00;
    test_reset();
    test_duty_50();
    test_extremes();
    test_double_buffer();
    test_mixed_modes();
    test_timebase_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
